board_word_loader: RTL and testbench

- Input-side companion to the Nexys 3 top wrapper. The wrapper shows CPU results on the LEDs one byte at a time, chosen by SEL. This block goes the other way: it assembles a 32-bit word from the 8 slide switches, one byte lane at a time.
- Raw push-buttons are synchronised and debounced. Staged bytes are published to the CPU side as one word with a valid pulse.
- Sits between board I/O pins and the CPU/top wrapper. Typical use is injecting operands or instructions for bring-up.

---
 rtl/board_word_loader.sv | 159 +++++++++++++++
 tb/tb_board_word_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/board_word_loader.sv
// rtl/board_word_loader.sv - assembles a 32-bit word from slide switches via debounced buttons
// Two buttons share one debouncer module; the top stages bytes per lane and publishes them on commit.

module board_word_loader_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  typedef enum logic [1:0] {LOW, WAIT_HIGH, HIGH, WAIT_LOW} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               sync1, sync2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      state <= LOW;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive synced samples agree.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pulse      = 1'b0;
    case (state)
      LOW: begin
        if (sync2) begin
          state_next = WAIT_HIGH;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!sync2) begin
          state_next = LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          state_next = HIGH;
          cnt_next   = '0;
          pulse      = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!sync2) begin
          state_next = WAIT_LOW;
          cnt_next   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (sync2) begin
          state_next = HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          state_next = LOW;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

module board_word_loader #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  SW,
  input  logic [1:0]  SEL,
  input  logic        BTN_LOAD,
  input  logic        BTN_COMMIT,
  output logic [31:0] STAGE,
  output logic [3:0]  LANE_MASK,
  output logic [31:0] WORD,
  output logic        WORD_VALID,
  output logic        COMMIT_ERR
);

  logic        load_pulse, commit_pulse;
  logic [31:0] stage_next;
  logic [3:0]  mask_next;

  board_word_loader_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_load_db (
    .clk   (CLK),
    .rst   (RST),
    .raw   (BTN_LOAD),
    .pulse (load_pulse)
  );

  board_word_loader_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_commit_db (
    .clk   (CLK),
    .rst   (RST),
    .raw   (BTN_COMMIT),
    .pulse (commit_pulse)
  );

  // Load is folded in first so a coinciding commit sees the freshly written lane.
  always_comb begin
    stage_next = STAGE;
    mask_next  = LANE_MASK;
    if (load_pulse) begin
      stage_next[{SEL, 3'b000} +: 8] = SW;
      mask_next[SEL]                 = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      STAGE      <= '0;
      LANE_MASK  <= '0;
      WORD       <= '0;
      WORD_VALID <= 1'b0;
      COMMIT_ERR <= 1'b0;
    end else begin
      STAGE      <= stage_next;
      LANE_MASK  <= mask_next;
      WORD_VALID <= 1'b0;
      COMMIT_ERR <= 1'b0;
      if (commit_pulse) begin
        if (mask_next == 4'hF) begin
          WORD       <= stage_next;
          WORD_VALID <= 1'b1;
          LANE_MASK  <= '0;
        end else begin
          COMMIT_ERR <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_board_word_loader.sv
// tb/tb_board_word_loader.sv - directed self-checking bench for board_word_loader
// Inputs change 1 time unit after a rising edge; pulse outputs are tallied on falling edges.

module tb_board_word_loader;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  SW = '0;
  logic [1:0]  SEL = '0;
  logic        BTN_LOAD = 1'b0;
  logic        BTN_COMMIT = 1'b0;
  logic [31:0] STAGE;
  logic [3:0]  LANE_MASK;
  logic [31:0] WORD;
  logic        WORD_VALID;
  logic        COMMIT_ERR;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int ecount = 0;
  int overlap = 0;
  int v0, e0;

  board_word_loader #(.DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW         (SW),
    .SEL        (SEL),
    .BTN_LOAD   (BTN_LOAD),
    .BTN_COMMIT (BTN_COMMIT),
    .STAGE      (STAGE),
    .LANE_MASK  (LANE_MASK),
    .WORD       (WORD),
    .WORD_VALID (WORD_VALID),
    .COMMIT_ERR (COMMIT_ERR)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (WORD_VALID === 1'b1) vcount++;
    if (COMMIT_ERR === 1'b1) ecount++;
    if (WORD_VALID === 1'b1 && COMMIT_ERR === 1'b1) overlap++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic press_load(input logic [1:0] sel, input logic [7:0] sw);
    SEL = sel;
    SW = sw;
    BTN_LOAD = 1'b1;
    tick(8);
    BTN_LOAD = 1'b0;
    tick(10);
  endtask

  task automatic press_commit();
    BTN_COMMIT = 1'b1;
    tick(8);
    BTN_COMMIT = 1'b0;
    tick(10);
  endtask

  initial begin
    // Reset and idle
    tick(3);
    check("rst_stage", STAGE, 32'h0);
    check("rst_mask", {28'h0, LANE_MASK}, 32'h0);
    check("rst_word", WORD, 32'h0);
    check("rst_valid", {31'h0, WORD_VALID}, 32'h0);
    check("rst_err", {31'h0, COMMIT_ERR}, 32'h0);
    RST = 1'b1;
    tick(20);
    check("idle_stage", STAGE, 32'h0);
    check("idle_mask", {28'h0, LANE_MASK}, 32'h0);
    check("idle_word", WORD, 32'h0);
    check("idle_valid_cnt", vcount, 0);
    check("idle_err_cnt", ecount, 0);

    // Held load: update lands exactly on the 7th edge after the input changes
    SEL = 2'd2;
    SW = 8'hA5;
    BTN_LOAD = 1'b1;
    tick(6);
    check("load_not_early", STAGE, 32'h0);
    tick(1);
    check("load_stage", STAGE, 32'h00A50000);
    check("load_mask", {28'h0, LANE_MASK}, 32'h4);
    SW = 8'hFF;
    tick(20);
    check("held_once_stage", STAGE, 32'h00A50000);
    BTN_LOAD = 1'b0;
    tick(10);

    // Bounce shorter than the debounce window
    SEL = 2'd0;
    SW = 8'h11;
    BTN_LOAD = 1'b1; tick(1);
    BTN_LOAD = 1'b0; tick(1);
    BTN_LOAD = 1'b1; tick(1);
    BTN_LOAD = 1'b1; tick(1);
    BTN_LOAD = 1'b0; tick(15);
    check("glitch_stage", STAGE, 32'h00A50000);
    check("glitch_mask", {28'h0, LANE_MASK}, 32'h4);

    // Full word commit
    press_load(2'd0, 8'h78);
    press_load(2'd1, 8'h56);
    press_load(2'd2, 8'h34);
    press_load(2'd3, 8'h12);
    check("full_stage", STAGE, 32'h12345678);
    check("full_mask", {28'h0, LANE_MASK}, 32'hF);
    v0 = vcount;
    e0 = ecount;
    press_commit();
    check("commit_word", WORD, 32'h12345678);
    check("commit_valid_cnt", vcount - v0, 1);
    check("commit_no_err", ecount - e0, 0);
    check("commit_mask", {28'h0, LANE_MASK}, 32'h0);
    check("commit_stage_kept", STAGE, 32'h12345678);

    // Partial commit is refused
    press_load(2'd0, 8'h9A);
    v0 = vcount;
    e0 = ecount;
    press_commit();
    check("partial_err_cnt", ecount - e0, 1);
    check("partial_no_valid", vcount - v0, 0);
    check("partial_word", WORD, 32'h12345678);
    check("partial_mask", {28'h0, LANE_MASK}, 32'h1);
    check("partial_stage", STAGE, 32'h1234569A);

    // Coinciding load and commit complete the word
    press_load(2'd1, 8'hBC);
    press_load(2'd2, 8'hF0);
    check("pre_both_mask", {28'h0, LANE_MASK}, 32'h7);
    v0 = vcount;
    e0 = ecount;
    SEL = 2'd3;
    SW = 8'hDE;
    BTN_LOAD = 1'b1;
    BTN_COMMIT = 1'b1;
    tick(8);
    BTN_LOAD = 1'b0;
    BTN_COMMIT = 1'b0;
    tick(10);
    check("both_word", WORD, 32'hDEF0BC9A);
    check("both_valid_cnt", vcount - v0, 1);
    check("both_no_err", ecount - e0, 0);
    check("both_mask", {28'h0, LANE_MASK}, 32'h0);
    check("both_stage", STAGE, 32'hDEF0BC9A);

    // Reset while the commit button is mid-debounce and kept held
    v0 = vcount;
    e0 = ecount;
    BTN_COMMIT = 1'b1;
    tick(4);
    RST = 1'b0;
    tick(2);
    check("mid_rst_no_err", ecount - e0, 0);
    check("mid_rst_no_valid", vcount - v0, 0);
    check("mid_rst_word", WORD, 32'h0);
    RST = 1'b1;
    tick(6);
    check("post_rst_not_early", {31'h0, COMMIT_ERR}, 32'h0);
    tick(1);
    check("post_rst_err", {31'h0, COMMIT_ERR}, 32'h1);
    check("post_rst_no_valid", {31'h0, WORD_VALID}, 32'h0);
    tick(1);
    check("post_rst_err_drop", {31'h0, COMMIT_ERR}, 32'h0);
    tick(20);
    check("post_rst_err_once", ecount - e0, 1);
    BTN_COMMIT = 1'b0;
    tick(10);
    check("never_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
